// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: MDU sequencer
// state encoding and the hard-wired zero register address.
package pipe_ctrl_pkg;

  typedef enum logic {
    ST_RUN = 1'b0,
    ST_MDU = 1'b1
  } mdu_state_e;

  localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/pipe_ctrl_mdu_seq.sv
// MDU occupancy sequencer: holds the EX stage for MDU_LAT cycles once a
// mul/div is seen in RUN, then pulses done for one cycle on the way back.
module pipe_ctrl_mdu_seq
  import pipe_ctrl_pkg::*;
#(
  parameter int MDU_LAT = 64,
  parameter int CNT_W   = $clog2(MDU_LAT)
) (
  input  logic clk,
  input  logic rst,
  input  logic start_i,
  input  logic hold_i,
  output logic busy_o,
  output logic done_o
);

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MDU_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next state, countdown and busy/done; a memory hold freezes everything,
  // including the done pulse so it is only ever seen once.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_o  = 1'b0;
    done_o  = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (start_i) begin
          busy_o = 1'b1;
          if (!hold_i) begin
            state_d = ST_MDU;
            cnt_d   = CNT_INIT;
          end
        end
      end
      ST_MDU: begin
        if (cnt_q != '0) begin
          busy_o = 1'b1;
          if (!hold_i) begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end else if (!hold_i) begin
          done_o  = 1'b1;
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // State and counter registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline: turns memory
// wait, MDU occupancy, EX redirects and load-use hazards into stall/flush
// strobes, and counts the cycles in which the PC was held.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MDU_LAT = 64,
  parameter int CNT_W   = $clog2(MDU_LAT)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_jump_en_i,
  input  logic [63:0] ex_jump_addr_i,
  input  logic        ex_mdu_start_i,
  input  logic        ex_load_i,
  input  logic [4:0]  ex_rd_addr_i,
  input  logic [4:0]  id_rs1_addr_i,
  input  logic [4:0]  id_rs2_addr_i,
  input  logic        id_rs1_used_i,
  input  logic        id_rs2_used_i,
  input  logic        mem_req_i,
  input  logic        mem_ready_i,
  output logic        stall_pc_o,
  output logic        stall_if_id_o,
  output logic        stall_id_ex_o,
  output logic        stall_ex_mem_o,
  output logic        flush_if_id_o,
  output logic        flush_id_ex_o,
  output logic        jump_en_o,
  output logic [63:0] jump_addr_o,
  output logic        mdu_done_o,
  output logic [31:0] stall_cnt_o
);

  logic        mem_hold;
  logic        mdu_busy;
  logic        mdu_done;
  logic        load_use;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  assign mem_hold = mem_req_i & ~mem_ready_i;

  pipe_ctrl_mdu_seq #(
    .MDU_LAT (MDU_LAT),
    .CNT_W   (CNT_W)
  ) u_mdu_seq (
    .clk     (clk),
    .rst     (rst),
    .start_i (ex_mdu_start_i),
    .hold_i  (mem_hold),
    .busy_o  (mdu_busy),
    .done_o  (mdu_done)
  );

  // Load-use hazard: the load in EX writes a register the ID instruction reads.
  always_comb begin
    load_use = ex_load_i && (ex_rd_addr_i != REG_X0) &&
               ((id_rs1_used_i && (id_rs1_addr_i == ex_rd_addr_i)) ||
                (id_rs2_used_i && (id_rs2_addr_i == ex_rd_addr_i)));
  end

  // Priority resolution: memory wait, MDU busy, redirect, load-use, idle.
  // Everything is forced low while reset is held.
  always_comb begin
    stall_pc_o     = 1'b0;
    stall_if_id_o  = 1'b0;
    stall_id_ex_o  = 1'b0;
    stall_ex_mem_o = 1'b0;
    flush_if_id_o  = 1'b0;
    flush_id_ex_o  = 1'b0;
    jump_en_o      = 1'b0;
    jump_addr_o    = '0;
    mdu_done_o     = 1'b0;
    stall_cnt_o    = '0;
    if (rst) begin
      stall_cnt_o = stall_cnt_q;
      mdu_done_o  = mdu_done;
      if (mem_hold) begin
        stall_pc_o     = 1'b1;
        stall_if_id_o  = 1'b1;
        stall_id_ex_o  = 1'b1;
        stall_ex_mem_o = 1'b1;
      end else if (mdu_busy) begin
        stall_pc_o    = 1'b1;
        stall_if_id_o = 1'b1;
        stall_id_ex_o = 1'b1;
      end else if (ex_jump_en_i) begin
        jump_en_o     = 1'b1;
        jump_addr_o   = ex_jump_addr_i;
        flush_if_id_o = 1'b1;
        flush_id_ex_o = 1'b1;
      end else if (load_use) begin
        stall_pc_o    = 1'b1;
        stall_if_id_o = 1'b1;
        flush_id_ex_o = 1'b1;
      end
    end
  end

  // Stall-cycle counter advances on every cycle the PC is held; wraps freely.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_pc_o) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  // Performance counter register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // A redirect and a mul/div can never legitimately sit in EX together.
  a_no_jump_with_mdu : assert property (@(posedge clk) disable iff (!rst)
    !(ex_jump_en_i && ex_mdu_start_i));

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl with a short MDU latency: a vector table
// for the single-cycle priority cases, hand-written multi-cycle sequences,
// and a queue of expected outputs consumed as the DUT responds.
module tb_pipe_ctrl;

  localparam logic [6:0] F_NONE = 7'b0000000;
  localparam logic [6:0] F_LU   = 7'b1100010;
  localparam logic [6:0] F_JMP  = 7'b0000111;
  localparam logic [6:0] F_MEM  = 7'b1111000;
  localparam logic [6:0] F_MDU  = 7'b1110000;

  typedef struct {
    string       name;
    logic        r;
    logic        j;
    logic [63:0] ja;
    logic        m;
    logic        ld;
    logic [4:0]  rd;
    logic [4:0]  s1;
    logic [4:0]  s2;
    logic        u1;
    logic        u2;
    logic        mq;
    logic        mr;
    logic [6:0]  ef;
    logic [63:0] ea;
    logic        ed;
  } vec_t;

  typedef struct {
    string       name;
    logic [6:0]  flags;
    logic [63:0] addr;
    logic        done;
    logic [31:0] cnt;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        ex_jump_en_i;
  logic [63:0] ex_jump_addr_i;
  logic        ex_mdu_start_i;
  logic        ex_load_i;
  logic [4:0]  ex_rd_addr_i;
  logic [4:0]  id_rs1_addr_i;
  logic [4:0]  id_rs2_addr_i;
  logic        id_rs1_used_i;
  logic        id_rs2_used_i;
  logic        mem_req_i;
  logic        mem_ready_i;
  logic        stall_pc_o;
  logic        stall_if_id_o;
  logic        stall_id_ex_o;
  logic        stall_ex_mem_o;
  logic        flush_if_id_o;
  logic        flush_id_ex_o;
  logic        jump_en_o;
  logic [63:0] jump_addr_o;
  logic        mdu_done_o;
  logic [31:0] stall_cnt_o;

  int          errors;
  int          checks;
  logic [31:0] model_cnt;
  exp_t        sb[$];
  vec_t        tbl[$];

  pipe_ctrl #(.MDU_LAT(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .ex_jump_en_i   (ex_jump_en_i),
    .ex_jump_addr_i (ex_jump_addr_i),
    .ex_mdu_start_i (ex_mdu_start_i),
    .ex_load_i      (ex_load_i),
    .ex_rd_addr_i   (ex_rd_addr_i),
    .id_rs1_addr_i  (id_rs1_addr_i),
    .id_rs2_addr_i  (id_rs2_addr_i),
    .id_rs1_used_i  (id_rs1_used_i),
    .id_rs2_used_i  (id_rs2_used_i),
    .mem_req_i      (mem_req_i),
    .mem_ready_i    (mem_ready_i),
    .stall_pc_o     (stall_pc_o),
    .stall_if_id_o  (stall_if_id_o),
    .stall_id_ex_o  (stall_id_ex_o),
    .stall_ex_mem_o (stall_ex_mem_o),
    .flush_if_id_o  (flush_if_id_o),
    .flush_id_ex_o  (flush_id_ex_o),
    .jump_en_o      (jump_en_o),
    .jump_addr_o    (jump_addr_o),
    .mdu_done_o     (mdu_done_o),
    .stall_cnt_o    (stall_cnt_o)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(string name, logic r, logic j, logic [63:0] ja,
                              logic m, logic ld, logic [4:0] rd, logic [4:0] s1,
                              logic [4:0] s2, logic u1, logic u2, logic mq,
                              logic mr, logic [6:0] ef, logic [63:0] ea,
                              logic ed);
    vec_t v;
    v.name = name; v.r = r; v.j = j; v.ja = ja; v.m = m; v.ld = ld;
    v.rd = rd; v.s1 = s1; v.s2 = s2; v.u1 = u1; v.u2 = u2;
    v.mq = mq; v.mr = mr; v.ef = ef; v.ea = ea; v.ed = ed;
    return v;
  endfunction

  // Drive one cycle of inputs and queue what the DUT must show for it.
  task automatic applyStimulus(input vec_t v);
    exp_t e;
    rst            = v.r;
    ex_jump_en_i   = v.j;
    ex_jump_addr_i = v.ja;
    ex_mdu_start_i = v.m;
    ex_load_i      = v.ld;
    ex_rd_addr_i   = v.rd;
    id_rs1_addr_i  = v.s1;
    id_rs2_addr_i  = v.s2;
    id_rs1_used_i  = v.u1;
    id_rs2_used_i  = v.u2;
    mem_req_i      = v.mq;
    mem_ready_i    = v.mr;
    e.name  = v.name;
    e.flags = v.ef;
    e.addr  = v.ea;
    e.done  = v.ed;
    e.cnt   = v.r ? model_cnt : 32'd0;
    sb.push_back(e);
    if (!v.r) model_cnt = 32'd0;
    else if (v.ef[6]) model_cnt = model_cnt + 32'd1;
  endtask

  // Pop the oldest expectation and compare it against the live outputs.
  task automatic checkOutput();
    exp_t       e;
    logic [6:0] act;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("[TB] FAIL scoreboard: got empty queue, want an entry");
      return;
    end
    e = sb.pop_front();
    act = {stall_pc_o, stall_if_id_o, stall_id_ex_o, stall_ex_mem_o,
           flush_if_id_o, flush_id_ex_o, jump_en_o};
    if (act !== e.flags) begin
      errors++;
      $display("[TB] FAIL %s flags: got %b want %b", e.name, act, e.flags);
    end
    checks++;
    if (jump_addr_o !== e.addr) begin
      errors++;
      $display("[TB] FAIL %s jump_addr: got %h want %h", e.name, jump_addr_o, e.addr);
    end
    checks++;
    if (mdu_done_o !== e.done) begin
      errors++;
      $display("[TB] FAIL %s mdu_done: got %b want %b", e.name, mdu_done_o, e.done);
    end
    checks++;
    if (stall_cnt_o !== e.cnt) begin
      errors++;
      $display("[TB] FAIL %s stall_cnt: got %h want %h", e.name, stall_cnt_o, e.cnt);
    end
  endtask

  task automatic step(input vec_t v);
    applyStimulus(v);
    @(negedge clk);
    checkOutput();
    @(posedge clk);
    #1;
  endtask

  // Main sequence: table of single-cycle cases, then multi-cycle corners.
  initial begin
    errors    = 0;
    checks    = 0;
    model_cnt = 32'd0;
    applyStimulus(mk("init", 0,0,0,0,0,0,0,0,0,0,0,0, F_NONE,0,0));
    void'(sb.pop_front());
    @(posedge clk);
    #1;

    tbl.push_back(mk("reset",     0,0,0,               0,1,5,5,0,1,0,0,0, F_NONE,0,0));
    tbl.push_back(mk("idle",      1,0,0,               0,0,0,0,0,0,0,0,0, F_NONE,0,0));
    tbl.push_back(mk("lu_rs1",    1,0,0,               0,1,5,5,0,1,0,0,0, F_LU,0,0));
    tbl.push_back(mk("lu_x0",     1,0,0,               0,1,0,0,0,1,0,0,0, F_NONE,0,0));
    tbl.push_back(mk("lu_rs2",    1,0,0,               0,1,7,3,7,1,1,0,0, F_LU,0,0));
    tbl.push_back(mk("lu_unused", 1,0,0,               0,1,5,5,5,0,0,0,0, F_NONE,0,0));
    tbl.push_back(mk("no_load",   1,0,0,               0,0,5,5,0,1,0,0,0, F_NONE,0,0));
    tbl.push_back(mk("lu_ne",     1,0,0,               0,1,5,6,6,1,1,0,0, F_NONE,0,0));
    tbl.push_back(mk("jmp_lu",    1,1,64'h8000_0100,   0,1,5,5,0,1,0,0,0, F_JMP,64'h8000_0100,0));
    tbl.push_back(mk("jmp",       1,1,64'h1234_5678_9ABC, 0,0,0,0,0,0,0,0,0, F_JMP,64'h1234_5678_9ABC,0));
    tbl.push_back(mk("mem_jmp",   1,1,64'h1234,        0,0,0,0,0,0,0,1,0, F_MEM,0,0));
    tbl.push_back(mk("mem_rdy",   1,0,0,               0,0,0,0,0,0,0,1,1, F_NONE,0,0));
    tbl.push_back(mk("mem_lu",    1,0,0,               0,1,5,5,0,1,0,1,0, F_MEM,0,0));
    tbl.push_back(mk("idle2",     1,0,0,               0,0,0,0,0,0,0,0,1, F_NONE,0,0));
    foreach (tbl[i]) step(tbl[i]);

    // MDU occupancy: four stall cycles, then a single done pulse.
    for (int i = 0; i < 4; i++)
      step(mk("mdu_busy", 1,0,0,1,1,5,5,0,1,0,0,0, F_MDU,0,0));
    step(mk("mdu_done", 1,0,0,1,0,0,0,0,0,0,0,0, F_NONE,0,1));
    step(mk("mdu_after",1,0,0,0,0,0,0,0,0,0,0,0, F_NONE,0,0));

    // Memory wait in the middle of an MDU window stretches it by three.
    step(mk("mw_c1",    1,0,0,1,0,0,0,0,0,0,0,0, F_MDU,0,0));
    step(mk("mw_c2",    1,0,0,1,0,0,0,0,0,0,0,0, F_MDU,0,0));
    for (int i = 0; i < 3; i++)
      step(mk("mw_hold", 1,0,0,1,0,0,0,0,0,0,1,0, F_MEM,0,0));
    step(mk("mw_c3",    1,0,0,1,0,0,0,0,0,0,0,0, F_MDU,0,0));
    step(mk("mw_c4",    1,0,0,1,0,0,0,0,0,0,0,0, F_MDU,0,0));
    step(mk("mw_done",  1,0,0,1,0,0,0,0,0,0,0,0, F_NONE,0,1));
    step(mk("mw_after", 1,0,0,0,0,0,0,0,0,0,0,0, F_NONE,0,0));

    // Reset while the counter sits at 2: operation abandoned, back to RUN.
    step(mk("rm_c1",    1,0,0,1,0,0,0,0,0,0,0,0, F_MDU,0,0));
    step(mk("rm_c2",    1,0,0,1,0,0,0,0,0,0,0,0, F_MDU,0,0));
    step(mk("rm_reset", 0,0,0,1,1,5,5,0,1,0,0,0, F_NONE,0,0));
    step(mk("rm_run",   1,0,0,0,1,5,5,0,1,0,0,0, F_LU,0,0));
    step(mk("rm_idle",  1,0,0,0,0,0,0,0,0,0,0,0, F_NONE,0,0));

    // Counter wrap from all-ones.
    force dut.stall_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.stall_cnt_q;
    model_cnt = 32'hFFFF_FFFF;
    step(mk("wrap_stall", 1,0,0,0,1,9,0,9,0,1,0,0, F_LU,0,0));
    step(mk("wrap_zero",  1,0,0,0,0,0,0,0,0,0,0,0, F_NONE,0,0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
